// File: rtl/mem_responder_if.sv
// ----------------------------------------------------------------------------
// mem_responder_if
//   Request/response bus between the multi-cycle core (master) and the
//   memory responder (slave). The responder answers each request with a single
//   ready pulse. err qualifies that pulse, and busy covers the whole
//   transaction.
//
//   req    master->slave  request valid, sampled only while the slave is idle
//   we     master->slave  1 = store, 0 = load/fetch
//   addr   master->slave  byte address
//   wdata  master->slave  store data
//   wstrb  master->slave  store byte enables, bit i -> wdata[8i+7:8i]
//   rdata  slave->master  load data, zero unless ready=1
//   ready  slave->master  one-cycle completion pulse
//   err    slave->master  misaligned / out-of-range, valid with ready
//   busy   slave->master  high from accept until the cycle after ready
// ----------------------------------------------------------------------------
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the multi-cycle core's shared instruction/data
//   bus. It serves fetch, load and store requests from one word-addressed RAM.
//   Each request completes after LATENCY cycles with a single ready pulse.
//
//   Parameters
//     DEPTH_WORDS  RAM size in 32-bit words (power of two, >= 2)
//     LATENCY      accept-to-ready distance in cycles (1..15)
//     BASE_ADDR    byte address of word 0 (aligned to DEPTH_WORDS*4)
//
//   Ports
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     bus    mem_responder_if.slave (req/we/addr/wdata/wstrb in,
//            rdata/ready/err/busy out)
// ----------------------------------------------------------------------------
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  mem_responder_if.slave bus
);

  localparam int unsigned AW          = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RANGE_BYTES = 33'(DEPTH_WORDS) << 2;
  // WAIT lasts LATENCY-1 cycles, so the counter starts at LATENCY-2 and the
  // exit happens on the cycle it reads zero.
  localparam logic [3:0]  CNT_LOAD    = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic [31:0] offset;
  logic        acc_err;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH_WORDS];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: sequential state is always assigned with <= so that every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.req) state_d = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request capture and wait counter
  // Request fields are frozen at accept. Bus changes while busy are invisible.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (state_q == IDLE && bus.req) begin
      cnt_q   <= CNT_LOAD;
      we_q    <= bus.we;
      addr_q  <= bus.addr;
      wdata_q <= bus.wdata;
      wstrb_q <= bus.wstrb;
    end else if (state_q == WAIT && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Address decode on the captured address
  // Addresses below BASE_ADDR wrap to a huge offset and fail the unsigned
  // range check. Because BASE_ADDR is word aligned, offset[1:0] == addr[1:0].
  // --------------------------------------------------------------------------
  assign offset  = addr_q - BASE_ADDR;
  assign acc_err = (offset[1:0] != 2'b00) || ({1'b0, offset} >= RANGE_BYTES);
  assign idx     = offset[AW+1:2];

  // --------------------------------------------------------------------------
  // RAM write: commits on the RESP->IDLE edge. A reset in WAIT or RESP forces
  // state_q back to IDLE asynchronously, so an uncommitted store is dropped.
  // --------------------------------------------------------------------------
  // NOTE: the RAM array has no reset. Its contents are undefined after
  // power-up, and leaving it unreset lets it map onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (state_q == RESP && we_q && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from state, so reset clears them without a clock edge.
  // --------------------------------------------------------------------------
  always_comb begin
    bus.ready = 1'b0;
    bus.err   = 1'b0;
    bus.busy  = (state_q != IDLE);
    bus.rdata = '0;
    if (state_q == RESP) begin
      bus.ready = 1'b1;
      bus.err   = acc_err;
      if (!we_q && !acc_err) bus.rdata = mem[idx];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_responder
//   Three responders share one stimulus bus. req is steered to the instance
//   picked by sel, and outputs are read back through the same selector.
//     sel 0: LATENCY=2,  1024 words, base 0x0000_0000
//     sel 1: LATENCY=1,    64 words, base 0x0000_0000
//     sel 2: LATENCY=15,   64 words, base 0x0000_1000
//   Latency is measured as the number of rising edges from the accepting edge
//   to the edge that samples ready=1.
// ----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int L0 = 2;
  localparam int L1 = 1;
  localparam int L2 = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          sel = 0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;

  logic [31:0] rdata_m;
  logic        ready_m, err_m, busy_m;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();
  mem_responder_if bus2 ();

  assign bus0.req = req && (sel == 0);
  assign bus1.req = req && (sel == 1);
  assign bus2.req = req && (sel == 2);
  assign bus0.we = we;  assign bus0.addr = addr;  assign bus0.wdata = wdata;  assign bus0.wstrb = wstrb;
  assign bus1.we = we;  assign bus1.addr = addr;  assign bus1.wdata = wdata;  assign bus1.wstrb = wstrb;
  assign bus2.we = we;  assign bus2.addr = addr;  assign bus2.wdata = wdata;  assign bus2.wstrb = wstrb;

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(L0), .BASE_ADDR(32'h0000_0000))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  mem_responder #(.DEPTH_WORDS(64), .LATENCY(L1), .BASE_ADDR(32'h0000_0000))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));
  mem_responder #(.DEPTH_WORDS(64), .LATENCY(L2), .BASE_ADDR(32'h0000_1000))
    dut2 (.clk(clk), .reset(reset), .bus(bus2));

  always_comb begin
    case (sel)
      1: begin rdata_m = bus1.rdata; ready_m = bus1.ready; err_m = bus1.err; busy_m = bus1.busy; end
      2: begin rdata_m = bus2.rdata; ready_m = bus2.ready; err_m = bus2.err; busy_m = bus2.busy; end
      default: begin rdata_m = bus0.rdata; ready_m = bus0.ready; err_m = bus0.err; busy_m = bus0.busy; end
    endcase
  end

  function automatic int lat_of(input int s);
    case (s)
      1: return L1;
      2: return L2;
      default: return L0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp_v);
    end
  endtask

  // One complete transaction, including latency and busy/quiet-output checks.
  task automatic txn(input int s, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] st, input string tag,
                     output logic [31:0] rd, output logic er);
    bit got = 0;
    bit proto_ok = 1;
    int lat = 0;
    @(negedge clk);
    sel = s; req = 1'b1; we = w; addr = a; wdata = d; wstrb = st;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      if (busy_m !== 1'b1) proto_ok = 0;
      if (ready_m === 1'b1) begin
        got = 1;
        lat = j + 1;
        break;
      end
      if (rdata_m !== 32'h0 || err_m !== 1'b0) proto_ok = 0;
    end
    rd = rdata_m;
    er = err_m;
    check({tag, " ready seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, lat, lat_of(s));
    check({tag, " busy/quiet while pending"}, 32'(proto_ok), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check({tag, " busy,ready after response"}, {30'd0, busy_m, ready_m}, 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[20];

  initial begin
    logic [31:0] rd;
    logic        er;
    bit          got;
    int          rcyc[3];
    int          nr;

    // Directed vectors on instance 0 (LATENCY=2, 1024 words, base 0).
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1111, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'b0000, 32'h11BB_33DD, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b1, 32'h0000_0000, 32'h0102_0304, 4'b1111, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0FFC, 32'h55AA_55AA, 4'b1111, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 4'b0000, 32'h55AA_55AA, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0000, 32'h0102_0304, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0000, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF, 1'b0};
    vecs[13] = '{1'b1, 32'h0000_0012, 32'h0000_0000, 4'b1111, 32'h0000_0000, 1'b1};
    vecs[14] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF, 1'b0};
    vecs[15] = '{1'b1, 32'h0000_0024, 32'hCAFE_F00D, 4'b1111, 32'h0000_0000, 1'b0};
    vecs[16] = '{1'b1, 32'h0000_0024, 32'h7700_0000, 4'b1000, 32'h0000_0000, 1'b0};
    vecs[17] = '{1'b0, 32'h0000_0024, 32'h0000_0000, 4'b0000, 32'h77FE_F00D, 1'b0};
    vecs[18] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1};
    vecs[19] = '{1'b0, 32'h0000_1000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1};

    // Reset state, with the clock running.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ready,err,busy", {29'd0, ready_m, err_m, busy_m}, 32'd0);
    check("reset rdata", rdata_m, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
          $sformatf("vec%0d", i), rd, er);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // Address/we changes while in WAIT must not affect the captured request.
    txn(0, 1'b1, 32'h30, 32'hA5A5_A5A5, 4'hF, "pre30", rd, er);
    txn(0, 1'b1, 32'h34, 32'h5A5A_5A5A, 4'hF, "pre34", rd, er);
    @(negedge clk);
    sel = 0; req = 1'b1; we = 1'b0; addr = 32'h30;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'b1; addr = 32'h34; wdata = 32'h0; wstrb = 4'hF;
    got = 0;
    for (int j = 0; j < 40; j++) begin
      if (ready_m === 1'b1) begin got = 1; break; end
      @(posedge clk);
      @(negedge clk);
    end
    check("captured addr ready", 32'(got), 32'd1);
    check("captured addr rdata", rdata_m, 32'hA5A5_A5A5);
    txn(0, 1'b0, 32'h34, 32'h0, 4'h0, "post34", rd, er);
    check("post34 rdata", rd, 32'h5A5A_5A5A);

    // req held high: first ready after LATENCY edges, then every LATENCY+1.
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      sel = s; req = 1'b1; we = 1'b0; addr = (s == 2) ? 32'h1010 : 32'h10;
      nr = 0;
      for (int c = 0; c < 80 && nr < 3; c++) begin
        @(posedge clk);
        @(negedge clk);
        if (ready_m === 1'b1) begin
          rcyc[nr] = c;
          nr++;
        end
      end
      req = 1'b0;
      check($sformatf("b2b sel%0d readies", s), nr, 3);
      check($sformatf("b2b sel%0d first", s), rcyc[0], lat_of(s) - 1);
      check($sformatf("b2b sel%0d spacing1", s), rcyc[1] - rcyc[0], lat_of(s) + 1);
      check($sformatf("b2b sel%0d spacing2", s), rcyc[2] - rcyc[1], lat_of(s) + 1);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("b2b sel%0d idle", s), 32'(busy_m), 32'd0);
    end

    // Reset during WAIT of a store: no ready, no write, outputs clear at once.
    txn(0, 1'b1, 32'h40, 32'h1357_9BDF, 4'hF, "pre40", rd, er);
    @(negedge clk);
    sel = 0; req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check("mid-op in WAIT", {30'd0, busy_m, ready_m}, 32'd2);
    #1 reset = 1'b0;
    #1 check("async reset busy,ready", {30'd0, busy_m, ready_m}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("held reset ready,err,busy", {29'd0, ready_m, err_m, busy_m}, 32'd0);
    reset = 1'b1;
    txn(0, 1'b0, 32'h40, 32'h0, 4'h0, "after reset 40", rd, er);
    check("dropped store keeps 0x40", rd, 32'h1357_9BDF);

    // Reset during RESP of a load: ready/rdata drop without a clock edge.
    @(negedge clk);
    sel = 0; req = 1'b1; we = 1'b0; addr = 32'h40;
    got = 0;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      if (ready_m === 1'b1) begin got = 1; break; end
    end
    check("RESP reached", 32'(got), 32'd1);
    check("RESP rdata", rdata_m, 32'h1357_9BDF);
    #1 reset = 1'b0;
    #1 check("async reset in RESP rdata", rdata_m, 32'h0);
    check("async reset in RESP ready,busy", {30'd0, ready_m, busy_m}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // LATENCY=1 instance.
    txn(1, 1'b1, 32'h04, 32'h0F0F_0F0F, 4'hF, "L1 st", rd, er);
    check("L1 st err", 32'(er), 32'd0);
    txn(1, 1'b0, 32'h04, 32'h0, 4'h0, "L1 ld", rd, er);
    check("L1 ld rdata", rd, 32'h0F0F_0F0F);
    txn(1, 1'b0, 32'h100, 32'h0, 4'h0, "L1 oob", rd, er);
    check("L1 oob err,rdata", {er, rd[30:0]}, 32'h8000_0000);

    // LATENCY=15 instance with a non-zero base.
    txn(2, 1'b1, 32'h1008, 32'h89AB_CDEF, 4'hF, "L15 st", rd, er);
    check("L15 st err", 32'(er), 32'd0);
    txn(2, 1'b0, 32'h1008, 32'h0, 4'h0, "L15 ld", rd, er);
    check("L15 ld rdata", rd, 32'h89AB_CDEF);
    txn(2, 1'b0, 32'h0008, 32'h0, 4'h0, "L15 below base", rd, er);
    check("L15 below base err", 32'(er), 32'd1);
    txn(2, 1'b0, 32'h1100, 32'h0, 4'h0, "L15 past end", rd, er);
    check("L15 past end err", 32'(er), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
